// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-granular sharing of one FIFO write port.
// Ports: wclk/wrst_n, req_valid/last/data/ready, wfull/winc/wdata, gnt_id, busy, pkt_err/err_clr.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 16,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [ID_WIDTH-1:0]           gnt_id,
  output logic                          busy,
  output logic                          pkt_err,
  input  logic                          err_clr
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [ID_WIDTH:0] NREQ = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);
  localparam logic [ID_WIDTH-1:0] TOP_ID = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   pick;
  logic [ID_WIDTH-1:0]   cand;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic [ID_WIDTH:0]     sum;
  logic                  found;
  logic [CNT_W-1:0]      beat_cnt;
  logic [DATA_WIDTH-1:0] data_a [NUM_REQ];
  logic                  sel_valid;
  logic                  sel_last;
  logic                  accept;
  logic                  forced;
  logic                  rel;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_a[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
      if (sum >= NREQ) sum = sum - NREQ;
      cand = sum[ID_WIDTH-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign sel_valid = req_valid[gnt_id];
  assign sel_last  = req_last[gnt_id];
  assign accept    = (state == LOCK) && sel_valid && !wfull;
  assign forced    = accept && (beat_cnt == LAST_CNT);
  assign rel       = accept && (sel_last || forced);
  assign next_ptr  = (gnt_id == TOP_ID) ? '0 : gnt_id + ID_WIDTH'(1);

  assign winc  = accept;
  assign wdata = data_a[gnt_id];
  assign busy  = (state == LOCK);

  always_comb begin
    req_ready = '0;
    if (state == LOCK && !wfull) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = LOCK;
      LOCK:    if (rel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rr_ptr   <= '0;
      gnt_id   <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        gnt_id   <= pick;
        beat_cnt <= '0;
      end
    end else if (accept) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
      if (rel) rr_ptr <= next_ptr;
    end
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)                 pkt_err <= 1'b0;
    else if (forced && !sel_last) pkt_err <= 1'b1;
    else if (err_clr)            pkt_err <= 1'b0;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vectors for the FIFO write-port arbiter.
// Clocks wclk, drives requesters, checks winc/wdata/req_ready/gnt_id/busy/pkt_err.
module tb_fifo_wr_arbiter;

  logic        wclk;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic [1:0]  gnt_id;
  logic        busy;
  logic        pkt_err;
  logic        err_clr;
  logic [7:0]  d [4];

  int n_vec = 0;
  int n_err = 0;

  assign req_data = {d[3], d[2], d[1], d[0]};

  fifo_wr_arbiter dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .pkt_err   (pkt_err),
    .err_clr   (err_clr)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lock_beat(input string tag, input int g,
                           input logic [7:0] dv);
    #1;
    chk({tag, ".busy"},  32'(busy),      32'd1);
    chk({tag, ".gnt"},   32'(gnt_id),    32'(g));
    chk({tag, ".winc"},  32'(winc),      32'd1);
    chk({tag, ".wdata"}, 32'(wdata),     32'(dv));
    chk({tag, ".ready"}, 32'(req_ready), 32'(1 << g));
  endtask

  task automatic idle_chk(input string tag);
    #1;
    chk({tag, ".busy"},  32'(busy),      32'd0);
    chk({tag, ".winc"},  32'(winc),      32'd0);
    chk({tag, ".ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic stall_chk(input string tag, input int g);
    #1;
    chk({tag, ".busy"},  32'(busy),      32'd1);
    chk({tag, ".gnt"},   32'(gnt_id),    32'(g));
    chk({tag, ".winc"},  32'(winc),      32'd0);
    chk({tag, ".ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    wrst_n    = 1'b0;
    req_valid = '0;
    req_last  = '0;
    wfull     = 1'b0;
    err_clr   = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 8'h00;

    // reset: requests present but nothing granted
    tick();
    req_valid = 4'b1111;
    idle_chk("rst");
    chk("rst.gnt", 32'(gnt_id), 32'd0);
    chk("rst.err", 32'(pkt_err), 32'd0);
    tick();
    idle_chk("rst2");
    req_valid = '0;
    wrst_n = 1'b1;

    // 1: three-beat packet from req 0
    req_valid = 4'b0001;
    d[0] = 8'hA1;
    idle_chk("t1.arb");
    tick();
    lock_beat("t1.b1", 0, 8'hA1);
    tick();
    d[0] = 8'hA2;
    lock_beat("t1.b2", 0, 8'hA2);
    tick();
    d[0] = 8'hA3;
    req_last = 4'b0001;
    lock_beat("t1.b3", 0, 8'hA3);
    tick();
    req_valid = '0;
    req_last = '0;
    idle_chk("t1.end");
    chk("t1.gnt_kept", 32'(gnt_id), 32'd0);

    // 2: reset with rr_ptr=1, then all four single-beat packets
    wrst_n = 1'b0;
    tick();
    wrst_n = 1'b1;
    req_valid = 4'b1111;
    req_last = 4'b1111;
    for (int i = 0; i < 4; i++) d[i] = 8'(8'h20 + i);
    idle_chk("t2.arb");
    for (int g = 0; g < 5; g++) begin
      tick();
      lock_beat("t2.grant", g % 4, 8'(8'h20 + g % 4));
      tick();
      idle_chk("t2.bubble");
    end
    req_valid = '0;
    req_last = '0;

    // 3: req 1 stalled by wfull for 5 cycles mid-packet
    req_valid = 4'b0010;
    d[1] = 8'hB1;
    tick();
    lock_beat("t3.b1", 1, 8'hB1);
    tick();
    d[1] = 8'hB2;
    wfull = 1'b1;
    stall_chk("t3.full", 1);
    repeat (4) begin
      tick();
      stall_chk("t3.full", 1);
    end
    tick();
    wfull = 1'b0;
    lock_beat("t3.b2", 1, 8'hB2);
    tick();
    d[1] = 8'hB3;
    req_last = 4'b0010;
    lock_beat("t3.b3", 1, 8'hB3);
    tick();
    req_valid = '0;
    req_last = '0;
    idle_chk("t3.end");

    // 4: req 2 streams without last; forced release at 16 beats
    req_valid = 4'b1100;
    req_last = 4'b1000;
    d[2] = 8'h40;
    d[3] = 8'hD3;
    tick();
    for (int b = 0; b < 16; b++) begin
      d[2] = 8'(8'h40 + b);
      err_clr = (b == 15);
      lock_beat("t4.beat", 2, 8'(8'h40 + b));
      chk("t4.err_hold", 32'(pkt_err), 32'd0);
      tick();
    end
    err_clr = 1'b0;
    idle_chk("t4.rel");
    chk("t4.set_wins", 32'(pkt_err), 32'd1);
    tick();
    lock_beat("t4.next", 3, 8'hD3);
    tick();
    req_valid = '0;
    req_last = '0;
    err_clr = 1'b1;
    idle_chk("t4.idle");
    chk("t4.err_sticky", 32'(pkt_err), 32'd1);
    tick();
    err_clr = 1'b0;
    #1;
    chk("t4.err_clr", 32'(pkt_err), 32'd0);

    // 5: reset asserted on beat 2 of a 4-beat packet
    req_valid = 4'b0001;
    d[0] = 8'hE1;
    tick();
    lock_beat("t5.b1", 0, 8'hE1);
    tick();
    d[0] = 8'hE2;
    lock_beat("t5.b2", 0, 8'hE2);
    wrst_n = 1'b0;
    idle_chk("t5.rst");
    chk("t5.gnt", 32'(gnt_id), 32'd0);
    tick();
    wrst_n = 1'b1;
    req_valid = '0;
    idle_chk("t5.post");

    // 6: rr_ptr=3 with req 0 and 3 both valid
    req_valid = 4'b0100;
    req_last = 4'b0100;
    d[2] = 8'h62;
    tick();
    lock_beat("t6.set", 2, 8'h62);
    tick();
    req_valid = 4'b1001;
    req_last = 4'b1001;
    d[0] = 8'h70;
    d[1] = 8'hEE;
    d[2] = 8'hEE;
    d[3] = 8'h73;
    idle_chk("t6.arb");
    tick();
    lock_beat("t6.r3", 3, 8'h73);
    tick();
    idle_chk("t6.gap");
    tick();
    lock_beat("t6.r0", 0, 8'h70);
    tick();
    req_valid = '0;
    req_last = '0;
    idle_chk("t6.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
